// File: rtl/dl_pkg.sv
// Shared definitions for the serial adder controller.
// Contents:
//   dl_sadd_state_t : FSM state encoding.
//                     IDLE=0, BUSY=1, DONE=2.
//                     Code 3 is unreachable and recovers to IDLE.
//   dl_clog2        : ceiling log2 with a minimum result of 1.
//                     Used to size index counters.
package dl_pkg;

  typedef enum logic [1:0] {
    DL_SADD_IDLE = 2'd0,
    DL_SADD_BUSY = 2'd1,
    DL_SADD_DONE = 2'd2,
    DL_SADD_RSVD = 2'd3
  } dl_sadd_state_t;

  // Never returns 0, so a counter built from it is always at least one bit wide.
  function automatic int unsigned dl_clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/dl_adder_cin.sv
// Combinational W-bit adder with carry-in and carry-out.
// Ports:
//   i_a    : W-bit operand
//   i_b    : W-bit operand
//   i_cin  : carry in
//   o_sum  : (i_a + i_b + i_cin) mod 2^W
//   o_cout : carry out of bit W-1
module dl_adder_cin #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign {o_cout, o_sum} = w_full;

endmodule

// File: rtl/dl_serial_adder_ctrl.sv
// Multi-cycle wide adder.
//   Reuses one CHUNK_BITS adder across NUM_CHUNKS chunks.
//   Processes the LSB chunk first.
//   Carries between chunks through a register.
// Optional feature, enabled by macro DL_SERIAL_ADDER_SUB_EN:
//   Adds port req_sub.
//   When req_sub=1 the block computes A-B.
// Ports:
//   clk, rst   : clock; synchronous active-high reset
//   req_valid  : request handshake, input
//   req_ready  : request handshake, output
//   req_a      : TOTAL_BITS operand A, latched on accept
//   req_b      : TOTAL_BITS operand B, latched on accept
//   req_sub    : subtract select (only with DL_SERIAL_ADDER_SUB_EN)
//   resp_valid : response handshake, output
//   resp_ready : response handshake, input
//   resp_sum   : (A+B) mod 2^TOTAL_BITS
//   resp_cout  : final chunk carry
//                For subtract: 1 means no borrow.
module dl_serial_adder_ctrl
  import dl_pkg::*;
#(
  parameter int unsigned CHUNK_BITS = 8,
  parameter int unsigned NUM_CHUNKS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [CHUNK_BITS*NUM_CHUNKS-1:0]   req_a,
  input  logic [CHUNK_BITS*NUM_CHUNKS-1:0]   req_b,
`ifdef DL_SERIAL_ADDER_SUB_EN
  input  logic                               req_sub,
`endif
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [CHUNK_BITS*NUM_CHUNKS-1:0]   resp_sum,
  output logic                               resp_cout
);

  localparam int unsigned       TOTAL_BITS = CHUNK_BITS * NUM_CHUNKS;
  localparam int unsigned       IDX_W      = dl_clog2(NUM_CHUNKS);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);

  dl_sadd_state_t          r_state;
  dl_sadd_state_t          w_state_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_carry;
  logic [TOTAL_BITS-1:0]   r_a;
  logic [TOTAL_BITS-1:0]   r_b;
  logic [TOTAL_BITS-1:0]   r_sum;

  logic                    w_accept;
  logic                    w_busy;
  logic                    w_req_ready;
  logic                    w_resp_valid;
  logic                    w_init_carry;
  logic [CHUNK_BITS-1:0]   w_a_chunk;
  logic [CHUNK_BITS-1:0]   w_b_raw;
  logic [CHUNK_BITS-1:0]   w_b_chunk;
  logic [CHUNK_BITS-1:0]   w_s_chunk;
  logic                    w_c_chunk;

  assign w_a_chunk = r_a[r_idx*CHUNK_BITS +: CHUNK_BITS];
  assign w_b_raw   = r_b[r_idx*CHUNK_BITS +: CHUNK_BITS];

`ifdef DL_SERIAL_ADDER_SUB_EN
  logic r_sub;
  // Two's-complement subtract: invert B chunk by chunk and seed the carry with 1.
  assign w_b_chunk    = r_sub ? ~w_b_raw : w_b_raw;
  assign w_init_carry = req_sub;
`else
  assign w_b_chunk    = w_b_raw;
  assign w_init_carry = 1'b0;
`endif

  dl_adder_cin #(.W(CHUNK_BITS)) u_adder (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_s_chunk),
    .o_cout (w_c_chunk)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= DL_SADD_IDLE;
    else     r_state <= w_state_nxt;
  end

  // req_ready depends only on r_state.
  // req_valid reaches only w_accept, so there is no combinational path to req_ready.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_accept     = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      DL_SADD_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = DL_SADD_BUSY;
        end
      end
      DL_SADD_BUSY: begin
        w_busy = 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = DL_SADD_DONE;
      end
      DL_SADD_DONE: begin
        w_resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = DL_SADD_IDLE;
      end
      default: w_state_nxt = DL_SADD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
`ifdef DL_SERIAL_ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= w_init_carry;
      r_a     <= req_a;
      r_b     <= req_b;
      r_sum   <= '0;
`ifdef DL_SERIAL_ADDER_SUB_EN
      r_sub   <= req_sub;
`endif
    end else if (w_busy) begin
      r_sum[r_idx*CHUNK_BITS +: CHUNK_BITS] <= w_s_chunk;
      r_carry <= w_c_chunk;
      // Wrap to 0 on the last chunk.
      // Keeps the index in range in DONE when NUM_CHUNKS is not a power of two.
      r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = w_resp_valid;
  assign resp_sum   = r_sum;
  assign resp_cout  = r_carry;

endmodule

// File: tb/tb_dl_serial_adder_ctrl.sv
module tb_dl_serial_adder_ctrl;

  localparam int unsigned CB = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned TW = CB * NC;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] req_a;
  logic [TW-1:0] req_b;
  logic          req_sub;
  logic          resp_valid;
  logic          resp_ready;
  logic [TW-1:0] resp_sum;
  logic          resp_cout;

  int n_pass  = 0;
  int n_total = 0;

  // Each entry is {cout, sum}.
  logic [TW:0] q_exp[$];

  dl_serial_adder_ctrl #(.CHUNK_BITS(CB), .NUM_CHUNKS(NC)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef DL_SERIAL_ADDER_SUB_EN
    .req_sub    (req_sub),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Pops and compares whenever a response handshake is about to complete at the next edge.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (q_exp.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_resp: got sum %h cout %b, expected no response", resp_sum, resp_cout);
      end else begin
        logic [TW:0] e;
        e = q_exp.pop_front();
        check("resp_sum",  64'(resp_sum),  64'(e[TW-1:0]));
        check("resp_cout", 64'(resp_cout), 64'(e[TW]));
      end
    end
  end

  task automatic wait_req_ready(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) check({name, "_ready_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (q_exp.size() == 0) break;
      @(negedge clk);
    end
    check({name, "_drain"}, 64'(q_exp.size()), 64'(0));
  endtask

  // Issues one request and checks that resp_valid rises exactly NC edges after the accept edge.
  task automatic do_op(input string name, input logic [TW-1:0] a, input logic [TW-1:0] b,
                       input logic sub, input logic [TW-1:0] es, input logic ec);
    wait_req_ready(name);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    q_exp.push_back({ec, es});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom();
    req_b     = $urandom();
    req_sub   = 1'b0;
    for (int k = 1; k <= int'(NC); k++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_lat"}, 64'(resp_valid), 64'(k == int'(NC)));
    end
    wait_drain(name);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = 1'b0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_sum",   64'(resp_sum),   64'(0));
    check("rst_resp_cout",  64'(resp_cout),  64'(0));
    check("rst_req_ready",  64'(req_ready),  64'(1));

    do_op("chunk_carry", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0);
    do_op("ripple_all",  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
    do_op("no_carry",    32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);

    // Back-pressure with a competing request held on req_valid.
    wait_req_ready("bp");
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_a      = 32'h80000000;
    req_b      = 32'h80000001;
    q_exp.push_back({1'b1, 32'h00000001});
    @(posedge clk);
    #1;
    req_a = 32'h00000010;
    req_b = 32'h00000020;
    q_exp.push_back({1'b0, 32'h00000030});
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (resp_valid) begin seen = 1; break; end
      end
      check("bp_valid_rise", 64'(seen), 64'(1));
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid",     64'(resp_valid), 64'(1));
      check("bp_sum",       64'(resp_sum),   64'(32'h00000001));
      check("bp_req_ready", 64'(req_ready),  64'(0));
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("bp_idle_ready", 64'(req_ready),  64'(1));
    check("bp_idle_valid", 64'(resp_valid), 64'(0));
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted", 64'(req_ready), 64'(0));
    wait_drain("bp");

    // Reset on the second BUSY cycle: the operation must vanish.
    wait_req_ready("rstmid");
    req_valid = 1'b1;
    req_a     = 32'h0000FFFF;
    req_b     = 32'h00000001;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", 64'(req_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstmid_no_resp", 64'(resp_valid), 64'(0));
    end
    do_op("after_rst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0);

`ifdef DL_SERIAL_ADDER_SUB_EN
    do_op("sub_borrow", 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0);
    do_op("sub_ok",     32'd7, 32'd5, 1'b1, 32'h00000002, 1'b1);
`endif

    wait_drain("final");
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
